// File: rtl/aes_byte_loader.sv
// -----------------------------------------------------------------------------
// aes_byte_loader
//
// Purpose:
//   Collects a stream of bytes into a 4x4 AES state matrix (column-major
//   order) and presents it, together with a 4x4 key matrix, to a cipher core
//   through a valid/ready handoff. The loader alternates between two states:
//   FILL accepts 16 data bytes, FULL holds the block until the downstream
//   takes it. A full block therefore costs 17 cycles when neither side stalls.
//
// Optional feature (macro AES_LOADER_KEY_STREAM_EN):
//   undefined : key is loaded in parallel from key_in at the moment the 16th
//               data byte is accepted, and held until the next block completes.
//   defined   : key_in is removed; bytes tagged with in_is_key are written into
//               the key matrix through a separate wrapping 4-bit key counter.
//               Key bytes do not advance the data counter or the FSM, are only
//               taken in FILL, and the key matrix persists across blocks.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_byte    in   [7:0] stream byte
//   in_valid   in   in_byte is valid
//   in_ready   out  loader accepts a byte this cycle (registered)
//   key_in     in   [3:0][3:0][7:0] parallel key, [row][col] (macro undefined)
//   in_is_key  in   in_byte is a key byte (macro defined)
//   data       out  [3:0][3:0][7:0] assembled state matrix, [row][col]
//   key        out  [3:0][3:0][7:0] key matrix, [row][col]
//   out_valid  out  data/key hold a complete block (registered)
//   out_ready  in   downstream consumes the block
// -----------------------------------------------------------------------------
module aes_byte_loader (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef AES_LOADER_KEY_STREAM_EN
  input  logic                  in_is_key,
`else
  input  logic [3:0][3:0][7:0]  key_in,
`endif
  output logic [3:0][3:0][7:0]  data,
  output logic [3:0][3:0][7:0]  key,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0] state;
  logic [3:0] cnt;
  logic       accept;
  logic       data_accept;

  // in_ready is only ever high in FILL, so no state qualifier is needed here.
  assign accept = in_valid & in_ready;

`ifdef AES_LOADER_KEY_STREAM_EN
  logic [3:0] kcnt;
  logic       key_accept;

  assign key_accept  = accept & in_is_key;
  assign data_accept = accept & ~in_is_key;

  // Key bytes land column-major like data bytes; kcnt wraps 15->0 on its own
  // and is independent of block boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt <= 4'd0;
      key  <= '0;
    end else if (key_accept) begin
      key[kcnt[1:0]][kcnt[3:2]] <= in_byte;
      kcnt                      <= kcnt + 4'd1;
    end
  end
`else
  assign data_accept = accept;

  // The key is captured together with the last data byte so that data and
  // key always describe the same block while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      key <= '0;
    end else if (data_accept && (cnt == 4'd15)) begin
      key <= key_in;
    end
  end
`endif

  // Main FSM. in_ready and out_valid are registered copies of the next state,
  // so neither depends combinationally on in_valid or out_ready. During reset
  // both are held low; in_ready rises on the first edge after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= 4'd0;
      data      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (data_accept) begin
            // Byte i goes to row i mod 4, column i div 4.
            data[cnt[1:0]][cnt[3:2]] <= in_byte;
            cnt                      <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state     <= FULL;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          if (out_ready) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FILL;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_byte_loader
//
// Directed, table-driven bench for aes_byte_loader. Expected matrices are
// built from the column-major mapping byte i -> [i mod 4][i div 4].
// Compiles with or without AES_LOADER_KEY_STREAM_EN.
// -----------------------------------------------------------------------------
module tb_aes_byte_loader;

  typedef logic [3:0][3:0][7:0] mat_t;

  typedef struct {
    logic [7:0] in_byte;
    int         row;
    int         col;
    logic       exp_valid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
`ifdef AES_LOADER_KEY_STREAM_EN
  logic       in_is_key;
`else
  mat_t       key_in;
`endif
  mat_t       data;
  mat_t       key;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int fails  = 0;
  int handoffs = 0;
  int ov_cycles = 0;
  mat_t got_q[$];
  mat_t exp_q[$];
  vec_t vecs[16];

  aes_byte_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef AES_LOADER_KEY_STREAM_EN
    .in_is_key (in_is_key),
`else
    .key_in    (key_in),
`endif
    .data      (data),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Record every handoff and every cycle out_valid is high.
  always @(posedge clk) begin
    if (!rst && out_valid) begin
      ov_cycles <= ov_cycles + 1;
      if (out_ready) begin
        handoffs <= handoffs + 1;
        got_q.push_back(data);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents one byte (called at posedge+1) and returns at posedge+1 after
  // the transfer edge, with in_valid already dropped.
  task automatic sendByte(input logic [7:0] b, input logic as_key);
    int n = 0;
    in_byte  = b;
    in_valid = 1'b1;
`ifdef AES_LOADER_KEY_STREAM_EN
    in_is_key = as_key;
`else
    if (as_key) $display("[TB] key byte request ignored in parallel-key build");
`endif
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 100 cycles, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef AES_LOADER_KEY_STREAM_EN
    in_is_key = 1'b0;
`endif
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    sendByte(b, 1'b0);
  endtask

  function automatic mat_t block_of(input logic [7:0] base);
    mat_t m;
    for (int i = 0; i < 16; i++) m[i % 4][i / 4] = base + 8'(i);
    return m;
  endfunction

  initial begin
    mat_t exp_m;
    mat_t bytes_m;
    int   h0;
    int   ov0;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{in_byte: 8'(i), row: i % 4, col: i / 4, exp_valid: (i == 15)};

    rst       = 1'b1;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef AES_LOADER_KEY_STREAM_EN
    in_is_key = 1'b0;
`else
    key_in    = {16{8'h2B}};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_data", data, '0);
    checkOutput("rst_key", key, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("post_rst_out_valid", 128'(out_valid), 128'(0));

    // Back-to-back block 0x00..0x0F
    $display("[TB] block 0x00..0x0F back-to-back");
    ov0 = ov_cycles;
    h0  = handoffs;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].in_byte);
      checkOutput($sformatf("out_valid_after_byte%0d", i), 128'(out_valid),
                  128'(vecs[i].exp_valid));
    end
    checkOutput("full_in_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("data[%0d][%0d]", vecs[i].row, vecs[i].col),
                  128'(data[vecs[i].row][vecs[i].col]),
                  128'(4 * vecs[i].col + vecs[i].row));
`ifndef AES_LOADER_KEY_STREAM_EN
    checkOutput("key_captured_2b", key, {16{8'h2B}});
`endif
    @(posedge clk); #1;
    checkOutput("handoff_in_ready", 128'(in_ready), 128'(1));
    checkOutput("handoff_out_valid", 128'(out_valid), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("out_valid_pulse_len", 128'(ov_cycles - ov0), 128'(1));
    checkOutput("handoff_count_1", 128'(handoffs - h0), 128'(1));

`ifndef AES_LOADER_KEY_STREAM_EN
    // key_in changes after completion; key holds until next block completes
    $display("[TB] key hold across block");
    key_in = {16{8'h7E}};
    for (int i = 0; i < 8; i++) applyStimulus(8'h40 + 8'(i));
    checkOutput("key_hold_mid_block", key, {16{8'h2B}});
    for (int i = 8; i < 15; i++) applyStimulus(8'h40 + 8'(i));
    checkOutput("key_hold_before_last", key, {16{8'h2B}});
    applyStimulus(8'h4F);
    checkOutput("key_update_7e", key, {16{8'h7E}});
    @(posedge clk); #1;
`endif

    // Downstream stall for 20 cycles, with upstream pushing a stray byte
    $display("[TB] downstream stall");
    out_ready = 1'b0;
    exp_m = block_of(8'h30);
    for (int i = 0; i < 16; i++) applyStimulus(8'h30 + 8'(i));
    h0 = handoffs;
    in_byte  = 8'hEE;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall_out_valid_c%0d", c), 128'(out_valid), 128'(1));
      checkOutput($sformatf("stall_in_ready_c%0d", c), 128'(in_ready), 128'(0));
      checkOutput($sformatf("stall_data_c%0d", c), data, exp_m);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_handoff_count", 128'(handoffs - h0), 128'(1));
    checkOutput("stall_release_in_ready", 128'(in_ready), 128'(1));
    checkOutput("stall_release_out_valid", 128'(out_valid), 128'(0));
    checkOutput("stall_data_kept", data, exp_m);

    // Reset mid-block discards partial block
    $display("[TB] reset mid-block");
    for (int i = 0; i < 7; i++) applyStimulus(8'h50 + 8'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_data", data, '0);
    checkOutput("midrst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_release_in_ready", 128'(in_ready), 128'(1));
    h0  = handoffs;
    ov0 = ov_cycles;
    for (int i = 0; i < 15; i++) applyStimulus(8'hA0 + 8'(i));
    checkOutput("midrst_no_early_valid", 128'(ov_cycles - ov0), 128'(0));
    checkOutput("midrst_out_valid_low", 128'(out_valid), 128'(0));
    applyStimulus(8'hAF);
    checkOutput("midrst_data00", 128'(data[0][0]), 128'(8'hA0));
    checkOutput("midrst_data33", 128'(data[3][3]), 128'(8'hAF));
    checkOutput("midrst_block", data, block_of(8'hA0));
    @(posedge clk); #1;
    checkOutput("midrst_handoff", 128'(handoffs - h0), 128'(1));

`ifdef AES_LOADER_KEY_STREAM_EN
    // Interleaved key/data stream; key counter was cleared by the reset above
    $display("[TB] interleaved key stream");
    for (int i = 0; i < 16; i++) begin
      sendByte(8'h10 + 8'(i), 1'b1);
      applyStimulus(8'h60 + 8'(i));
    end
    checkOutput("kstream_key12", 128'(key[1][2]), 128'(8'h19));
    checkOutput("kstream_key", key, block_of(8'h10));
    checkOutput("kstream_data", data, block_of(8'h60));
    @(posedge clk); #1;
    sendByte(8'h99, 1'b1);
    exp_m = block_of(8'h10);
    exp_m[0][0] = 8'h99;
    checkOutput("kstream_wrap_key", key, exp_m);
    checkOutput("kstream_key_no_fsm", 128'(in_ready), 128'(1));
`endif

    // Three blocks with random gaps, scoreboarded
    $display("[TB] three blocks with gaps");
    got_q.delete();
    exp_q.delete();
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        bytes_m[i % 4][i / 4] = b;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        applyStimulus(b);
      end
      exp_q.push_back(bytes_m);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_count", 128'(got_q.size()), 128'(3));
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("sb_block%0d", i),
                  (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
